// File: rtl/cpu_step_controller.sv
// CPU clock-enable sequencer: manual step, free-run, run-N cycles and run-to-breakpoint.
// cpuClkEn registered: step edge pulses next cycle, run edge pulses div+2 cycles later; no backpressure.
module cpu_step_controller #(
  parameter int PC_WIDTH    = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int DIV_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   stepBtn,
  input  logic                   runBtn,
  input  logic                   haltBtn,
  input  logic                   clearCount,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic [COUNT_WIDTH-1:0] stepCount,
  input  logic [PC_WIDTH-1:0]    breakpointPc,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   cpuClkEn,
  output logic                   running,
  output logic                   hitBreakpoint,
  output logic [COUNT_WIDTH-1:0] cycleCount
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BREAK = 2'd2} state_t;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_RUNN   = 2'd2;
  localparam logic [1:0] MODE_BREAK  = 2'd3;

  state_t                 state, stateNext;
  logic [1:0]             runMode, runModeNext;
  logic [DIV_WIDTH-1:0]   prescaler, prescalerNext;
  logic [COUNT_WIDTH-1:0] remaining, remainingNext;
  logic                   firstTick, firstTickNext;
  logic                   pulseNext;

  // Detectors remember "was low"; clearing them on reset means a held button is not an edge.
  logic stepWasLow, runWasLow, haltWasLow;
  logic stepEdge, runEdge, haltEdge, runOk, tick;

  assign stepEdge = stepBtn & stepWasLow;
  assign runEdge  = runBtn  & runWasLow;
  assign haltEdge = haltBtn & haltWasLow;
  assign runOk    = runEdge && (mode != MODE_MANUAL) &&
                    !((mode == MODE_RUNN) && (stepCount == '0));
  // >= keeps the prescaler from running away if div is lowered mid-run.
  assign tick     = (prescaler >= div);

  always_comb begin
    stateNext     = state;
    runModeNext   = runMode;
    prescalerNext = prescaler;
    remainingNext = remaining;
    firstTickNext = firstTick;
    pulseNext     = 1'b0;
    case (state)
      RUN: begin
        if (haltEdge) begin
          stateNext = IDLE;
        end else if (tick) begin
          prescalerNext = '0;
          firstTickNext = 1'b0;
          pulseNext     = 1'b1;
          if (runMode == MODE_RUNN) begin
            remainingNext = remaining - COUNT_WIDTH'(1);
            if (remaining == COUNT_WIDTH'(1)) stateNext = IDLE;
          end else if ((runMode == MODE_BREAK) && !firstTick && (pc == breakpointPc)) begin
            pulseNext = 1'b0;
            stateNext = BREAK;
          end
        end else begin
          prescalerNext = prescaler + DIV_WIDTH'(1);
        end
      end
      default: begin
        if (runOk) begin
          stateNext     = RUN;
          runModeNext   = mode;
          remainingNext = stepCount;
          prescalerNext = '0;
          firstTickNext = 1'b1;
        end else if (stepEdge) begin
          pulseNext = 1'b1;
          stateNext = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      runMode    <= '0;
      prescaler  <= '0;
      remaining  <= '0;
      firstTick  <= 1'b0;
      stepWasLow <= 1'b0;
      runWasLow  <= 1'b0;
      haltWasLow <= 1'b0;
      cpuClkEn   <= 1'b0;
      cycleCount <= '0;
    end else begin
      state      <= stateNext;
      runMode    <= runModeNext;
      prescaler  <= prescalerNext;
      remaining  <= remainingNext;
      firstTick  <= firstTickNext;
      stepWasLow <= ~stepBtn;
      runWasLow  <= ~runBtn;
      haltWasLow <= ~haltBtn;
      cpuClkEn   <= pulseNext;
      if (clearCount) begin
        cycleCount <= '0;
      end else if (pulseNext) begin
        cycleCount <= cycleCount + COUNT_WIDTH'(1);
      end
    end
  end

  assign running       = (state == RUN);
  assign hitBreakpoint = (state == BREAK);

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: expected pulse cycles and counts are queued, then matched by a pulse monitor.
module tb_cpu_step_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        stepBtn = 1'b0, runBtn = 1'b0, haltBtn = 1'b0, clearCount = 1'b0;
  logic [7:0]  div = 8'd0;
  logic [3:0]  stepCount = 4'd0;
  logic [31:0] breakpointPc = 32'd0;
  logic [31:0] pc;
  logic        cpuClkEn, running, hitBreakpoint;
  logic [3:0]  cycleCount;

  cpu_step_controller #(.PC_WIDTH(32), .COUNT_WIDTH(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .stepBtn(stepBtn), .runBtn(runBtn),
    .haltBtn(haltBtn), .clearCount(clearCount), .div(div), .stepCount(stepCount),
    .breakpointPc(breakpointPc), .pc(pc), .cpuClkEn(cpuClkEn), .running(running),
    .hitBreakpoint(hitBreakpoint), .cycleCount(cycleCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU stand-in: pc advances by 4 on every enable pulse.
  bit pcClear = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'd0;
    else if (pcClear) pc <= 32'd0;
    else if (cpuClkEn) pc <= pc + 32'd4;
  end

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sbQ[$];
  exp_t       monE;
  logic [3:0] expCount = 4'd0;
  int         errors = 0;
  int         checks = 0;

  always @(negedge clk) begin
    if (rst && cpuClkEn) begin
      checks = checks + 1;
      if (sbQ.size() == 0) begin
        errors = errors + 1;
        $display("FAIL pulse_unexpected cycle=%0d cpuClkEn=1 required no pulse", cyc);
      end else begin
        monE = sbQ.pop_front();
        if (monE.cyc !== cyc || monE.cnt !== cycleCount) begin
          errors = errors + 1;
          $display("FAIL pulse_match got cycle=%0d count=%0d required cycle=%0d count=%0d",
                   cyc, cycleCount, monE.cyc, monE.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cycle=%0d required completion", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectPulse(input int c, input bit clr);
    expCount = clr ? 4'd0 : expCount + 4'd1;
    sbQ.push_back('{c, expCount});
  endtask

  task automatic clearCounter();
    clearCount = 1'b1;
    cycles(1);
    clearCount = 1'b0;
    expCount = 4'd0;
  endtask

  task automatic checkDrain(input string name);
    for (int i = 0; i < 50 && sbQ.size() != 0; i++) cycles(1);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stepBtn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpuClkEn !== 1'b0) begin errors++; $display("FAIL reset_en got %b required 0", cpuClkEn); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b required 0", running); end
    checks++; if (hitBreakpoint !== 1'b0) begin errors++; $display("FAIL reset_break got %b required 0", hitBreakpoint); end
    checks++; if (cycleCount !== 4'd0) begin errors++; $display("FAIL reset_count got %0d required 0", cycleCount); end
    rst = 1'b1;
    cycles(4);
    stepBtn = 1'b0;
    cycles(2);
    checkDrain("reset_held_step");
  endtask

  task automatic test_step();
    for (int k = 0; k < 3; k++) begin
      stepBtn = 1'b1;
      expectPulse(cyc + 1, 1'b0);
      cycles(5);
      stepBtn = 1'b0;
      cycles(3);
    end
    checkDrain("step");
    checks++; if (cycleCount !== 4'd3) begin errors++; $display("FAIL step_count got %0d required 3", cycleCount); end
  endtask

  task automatic test_ignored();
    mode = 2'd0;
    runBtn = 1'b1;
    cycles(1);
    runBtn = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ignore_mode0 running=%b required 0", running); end
    cycles(2);
    mode = 2'd2;
    stepCount = 4'd0;
    runBtn = 1'b1;
    cycles(1);
    runBtn = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ignore_zero_budget running=%b required 0", running); end
    cycles(4);
    checkDrain("ignored");
  endtask

  task automatic test_run_n();
    int n;
    clearCounter();
    mode = 2'd2;
    stepCount = 4'd5;
    div = 8'd3;
    runBtn = 1'b1;
    n = cyc;
    for (int k = 0; k < 5; k++) expectPulse(n + 5 + 4 * k, 1'b0);
    cycles(1);
    runBtn = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL runn_start running=%b required 1", running); end
    cycles(20);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL runn_stop running=%b required 0", running); end
    checkDrain("runn");
    checks++; if (cycleCount !== 4'd5) begin errors++; $display("FAIL runn_count got %0d required 5", cycleCount); end
  endtask

  task automatic test_breakpoint();
    int n;
    clearCounter();
    pcClear = 1'b1;
    cycles(1);
    pcClear = 1'b0;
    mode = 2'd3;
    div = 8'd1;
    breakpointPc = 32'h10;
    runBtn = 1'b1;
    n = cyc;
    for (int k = 0; k < 4; k++) expectPulse(n + 3 + 2 * k, 1'b0);
    cycles(1);
    runBtn = 1'b0;
    cycles(11);
    checks++; if (hitBreakpoint !== 1'b1) begin errors++; $display("FAIL bp_hit got %b required 1", hitBreakpoint); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL bp_running got %b required 0", running); end
    checks++; if (cycleCount !== 4'd4) begin errors++; $display("FAIL bp_count got %0d required 4", cycleCount); end
    checkDrain("bp_first");
    // Resume while pc still equals the breakpoint: the first tick must still pulse.
    runBtn = 1'b1;
    n = cyc;
    expectPulse(n + 3, 1'b0);
    cycles(1);
    runBtn = 1'b0;
    checks++; if (hitBreakpoint !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL bp_resume break=%b running=%b required 0 1", hitBreakpoint, running);
    end
    cycles(3);
    haltBtn = 1'b1;
    cycles(1);
    haltBtn = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL bp_halt running=%b required 0", running); end
    checkDrain("bp_resume");
  endtask

  task automatic test_halt();
    int n;
    mode = 2'd1;
    div = 8'd0;
    runBtn = 1'b1;
    n = cyc;
    expectPulse(n + 2, 1'b0);
    expectPulse(n + 3, 1'b0);
    cycles(1);
    runBtn = 1'b0;
    cycles(2);
    haltBtn = 1'b1;
    cycles(1);
    checks++; if (cpuClkEn !== 1'b0) begin errors++; $display("FAIL halt_tick_en got %b required 0", cpuClkEn); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running got %b required 0", running); end
    haltBtn = 1'b0;
    cycles(2);
    checkDrain("halt");
  endtask

  task automatic test_wrap_clear();
    int n;
    clearCounter();
    mode = 2'd1;
    div = 8'd0;
    runBtn = 1'b1;
    n = cyc;
    for (int k = 0; k < 17; k++) expectPulse(n + 2 + k, 1'b0);
    cycles(1);
    runBtn = 1'b0;
    cycles(17);
    haltBtn = 1'b1;
    cycles(1);
    haltBtn = 1'b0;
    checks++; if (cycleCount !== 4'd1) begin errors++; $display("FAIL wrap_count got %0d required 1", cycleCount); end
    cycles(2);
    checkDrain("wrap");
    runBtn = 1'b1;
    n = cyc;
    expectPulse(n + 2, 1'b1);
    expectPulse(n + 3, 1'b0);
    expectPulse(n + 4, 1'b0);
    cycles(1);
    runBtn = 1'b0;
    clearCount = 1'b1;
    cycles(1);
    clearCount = 1'b0;
    checks++; if (cpuClkEn !== 1'b1 || cycleCount !== 4'd0) begin
      errors++; $display("FAIL clear_with_pulse en=%b count=%0d required 1 0", cpuClkEn, cycleCount);
    end
    cycles(2);
    haltBtn = 1'b1;
    cycles(1);
    haltBtn = 1'b0;
    checks++; if (cycleCount !== 4'd2) begin errors++; $display("FAIL clear_after got %0d required 2", cycleCount); end
    checkDrain("clear");
  endtask

  task automatic test_reset_mid_run();
    int n;
    mode = 2'd1;
    div = 8'd2;
    runBtn = 1'b1;
    n = cyc;
    expectPulse(n + 4, 1'b0);
    cycles(1);
    runBtn = 1'b0;
    cycles(6);
    checks++; if (cpuClkEn !== 1'b1) begin errors++; $display("FAIL midrun_pulse got %b required 1", cpuClkEn); end
    rst = 1'b0;
    runBtn = 1'b1;
    #1;
    checks++; if (cpuClkEn !== 1'b0) begin errors++; $display("FAIL midrun_rst_en got %b required 0", cpuClkEn); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrun_rst_running got %b required 0", running); end
    checks++; if (cycleCount !== 4'd0) begin errors++; $display("FAIL midrun_rst_count got %0d required 0", cycleCount); end
    expCount = 4'd0;
    cycles(3);
    rst = 1'b1;
    cycles(10);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL held_run_after_rst running=%b required 0", running); end
    runBtn = 1'b0;
    cycles(2);
    stepBtn = 1'b1;
    expectPulse(cyc + 1, 1'b0);
    cycles(2);
    stepBtn = 1'b0;
    cycles(2);
    checkDrain("after_reset");
  endtask

  initial begin
    #1;
    test_reset();
    test_step();
    test_ignored();
    test_run_n();
    test_breakpoint();
    test_halt();
    test_wrap_clear();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
